pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  clock; all state updates on rising edge.
REQ-002 SHALL have resetn  in  1  reset; synchronous and active-low.
REQ-003 SHALL have f_req  in  1  fetch stage wants an instruction this cycle.
REQ-004 SHALL have m_req  in  1  M stage holds a load/store.
REQ-005 SHALL have i_valid  out  1  ibus request valid.
REQ-006 SHALL have i_addr_ok, i_data_ok  in  1 each  ibus handshake.
REQ-007 SHALL have i_rdata  in  32  ibus read data.
REQ-008 SHALL have d_valid  out  1  dbus request valid.
REQ-009 SHALL have d_addr_ok, d_data_ok  in  1 each  dbus handshake.
REQ-010 SHALL have d_rdata  in  32  dbus read data.
REQ-011 SHALL have e_memtoreg  in  1  E-stage instruction is a load.
REQ-012 SHALL have e_wreg, d_rs, d_rt  in  5 each  E dest reg, D source regs.
REQ-013 SHALL have instr  out  32  fetched word to D stage.
REQ-014 SHALL have mdata  out  32  load word to W stage.
REQ-015 SHALL have StallF, StallD, StallE, StallM, StallW  out  1 each  pipeline-register hold.
REQ-016 SHALL have FlushD, FlushE, FlushM, FlushW  out  1 each  pipeline-register clear.

Function
REQ-017 SHALL contain two identical bus FSMs (ibus: req=f_req, adv=~StallF; dbus: req=m_req, adv=~StallM), states IDLE, ADDR, DATA, HOLD.
REQ-018 IDLE: valid=req; req&addr_ok&data_ok -> done this cycle, next IDLE if adv else HOLD; req&addr_ok&~data_ok -> DATA; req&~addr_ok -> ADDR; ~req -> IDLE.
REQ-019 ADDR: valid=1 held until addr_ok; addr_ok&data_ok -> done (IDLE/HOLD per adv); addr_ok only -> DATA; else stay.
REQ-020 DATA: valid=0; data_ok -> done (IDLE if adv, else HOLD); else stay.
REQ-021 HOLD: valid=0; done=1; output from 32-bit buffer; adv -> IDLE.
REQ-022 Buffer SHALL capture rdata on the cycle an FSM enters HOLD; never written otherwise.
REQ-023 instr/mdata SHALL equal the buffer in HOLD, else i_rdata/d_rdata (combinational, zero latency).
REQ-024 wait = ~done & (state!=IDLE | req); i_wait, d_wait derived per bus.
REQ-025 lu = e_memtoreg & (e_wreg!=0) & (e_wreg==d_rs | e_wreg==d_rt).
REQ-026 Priority 1, d_wait: StallF=StallD=StallE=StallM=1, FlushW=1, all else 0.
REQ-027 Priority 2, lu: StallF=StallD=1, FlushE=1, all else 0.
REQ-028 Priority 3, i_wait: StallF=1, FlushD=1, all else 0.
REQ-029 None active: all stall/flush outputs 0.
REQ-030 StallW and FlushM SHALL always be 0.
REQ-031 A bus completing while its stage is stalled by the other bus or lu SHALL enter HOLD and SHALL NOT re-issue the request.
REQ-032 valid SHALL never be withdrawn in ADDR before addr_ok, even if req drops.
REQ-033 Simultaneous addr_ok and data_ok in one cycle SHALL count as a complete transaction.

Reset
REQ-034 While resetn=0 at a clock edge, both FSMs SHALL go to IDLE and both buffers to 0.
REQ-035 While resetn=0, i_valid, d_valid and all stall/flush outputs SHALL be 0.
REQ-036 Reset mid-transaction SHALL abandon it; late data_ok from before reset SHALL be ignored in IDLE with req=0.

Verification
REQ-037 f_req=1, i_addr_ok=1, i_data_ok=1, i_rdata=0x24080001 in the same cycle -> instr=0x24080001, no stalls, ibus stays IDLE.
REQ-038 f_req=1, addr_ok at cycle 0, data_ok at cycle 3 -> i_valid high cycle 0 only; StallF=FlushD=1 cycles 0-2; both 0 at cycle 3.
REQ-039 m_req=1 with d_data_ok 2 cycles after addr_ok, ibus data 0x1234 arriving meanwhile -> StallF..M=1, FlushW=1 while waiting; ibus HOLD; instr=0x1234 after release; i_valid not re-asserted.
REQ-040 e_memtoreg=1, e_wreg=8, d_rt=8, no bus waits -> StallF=StallD=FlushE=1 one cycle; e_wreg=0 with d_rs=0 -> no stall.
REQ-041 lu and d_wait together -> d_wait pattern only (FlushE=0, FlushW=1).
REQ-042 resetn=0 during ibus DATA state, then late i_data_ok with f_req=0 -> FSM stays IDLE, no stall, instr buffer 0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: ibus/dbus handshake FSMs plus load-use
// detection, driving per-stage stall and flush controls.

module pipe_ctrl_bus (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        adv,
    input  logic        addrOk,
    input  logic        dataOk,
    input  logic [31:0] rdata,
    output logic        valid,
    output logic        done,
    output logic        busWait,
    output logic [31:0] rdataOut
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, HOLD} busState_t;

    busState_t   state, stNext;
    logic [31:0] holdBuf;

    always_comb begin
        valid  = 1'b0;
        done   = 1'b0;
        stNext = state;
        case (state)
            IDLE: begin
                valid = req;
                if (req) begin
                    if (addrOk && dataOk) done = 1'b1;
                    else if (addrOk)      stNext = DATA;
                    else                  stNext = ADDR;
                end
            end
            ADDR: begin
                valid = 1'b1;
                if (addrOk && dataOk) done = 1'b1;
                else if (addrOk)      stNext = DATA;
            end
            DATA: if (dataOk) done = 1'b1;
            HOLD: begin
                done = 1'b1;
                if (adv) stNext = IDLE;
            end
            default: stNext = IDLE;
        endcase
        // A completed beat the stage cannot take yet is parked in HOLD.
        if (done && state != HOLD) stNext = adv ? IDLE : HOLD;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= IDLE;
            holdBuf <= 32'h0;
        end else begin
            state <= stNext;
            if (stNext == HOLD && state != HOLD) holdBuf <= rdata;
        end
    end

    assign busWait  = ~done & ((state != IDLE) | req);
    assign rdataOut = (state == HOLD) ? holdBuf : rdata;
endmodule

module pipe_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic        f_req,
    input  logic        m_req,
    output logic        i_valid,
    input  logic        i_addr_ok,
    input  logic        i_data_ok,
    input  logic [31:0] i_rdata,
    output logic        d_valid,
    input  logic        d_addr_ok,
    input  logic        d_data_ok,
    input  logic [31:0] d_rdata,
    input  logic        e_memtoreg,
    input  logic [4:0]  e_wreg,
    input  logic [4:0]  d_rs,
    input  logic [4:0]  d_rt,
    output logic [31:0] instr,
    output logic [31:0] mdata,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        StallW,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushM,
    output logic        FlushW
);
    localparam int NUM_BUS = 2;  // index 0 = ibus, 1 = dbus

    logic [NUM_BUS-1:0]       req, adv, addrOk, dataOk, valid, done, busWait;
    logic [NUM_BUS-1:0][31:0] rdata, rdataOut;
    logic                     iWait, dWait, lu;

    assign req    = {m_req, f_req};
    assign adv    = {~StallM, ~StallF};
    assign addrOk = {d_addr_ok, i_addr_ok};
    assign dataOk = {d_data_ok, i_data_ok};
    assign rdata  = {d_rdata, i_rdata};

    for (genvar b = 0; b < NUM_BUS; b++) begin : gBus
        pipe_ctrl_bus uBus (
            .clk     (clk),
            .resetn  (resetn),
            .req     (req[b]),
            .adv     (adv[b]),
            .addrOk  (addrOk[b]),
            .dataOk  (dataOk[b]),
            .rdata   (rdata[b]),
            .valid   (valid[b]),
            .done    (done[b]),
            .busWait (busWait[b]),
            .rdataOut(rdataOut[b])
        );
    end

    assign i_valid = resetn & valid[0];
    assign d_valid = resetn & valid[1];
    assign instr   = rdataOut[0];
    assign mdata   = rdataOut[1];

    assign iWait = resetn & busWait[0];
    assign dWait = resetn & busWait[1];
    assign lu    = resetn & e_memtoreg & (e_wreg != 5'd0) &
                   ((e_wreg == d_rs) | (e_wreg == d_rt));

    always_comb begin
        StallF = 1'b0; StallD = 1'b0; StallE = 1'b0; StallM = 1'b0; StallW = 1'b0;
        FlushD = 1'b0; FlushE = 1'b0; FlushM = 1'b0; FlushW = 1'b0;
        if (dWait) begin
            StallF = 1'b1; StallD = 1'b1; StallE = 1'b1; StallM = 1'b1;
            FlushW = 1'b1;
        end else if (lu) begin
            StallF = 1'b1; StallD = 1'b1;
            FlushE = 1'b1;
        end else if (iWait) begin
            StallF = 1'b1;
            FlushD = 1'b1;
        end
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized and directed checks of pipe_ctrl against a transaction-level model.
module tb_pipe_ctrl;
    logic        clk = 1'b0;
    logic        resetn, f_req, m_req, i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
    logic        e_memtoreg;
    logic [4:0]  e_wreg, d_rs, d_rt;
    logic [31:0] i_rdata, d_rdata;
    logic        i_valid, d_valid;
    logic [31:0] instr, mdata;
    logic        StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, FlushM, FlushW;

    int total = 0;
    int bad   = 0;

    localparam logic [8:0] PAT_D  = 9'b11110_0001;
    localparam logic [8:0] PAT_LU = 9'b11000_0100;
    localparam logic [8:0] PAT_I  = 9'b10000_1000;

    pipe_ctrl dut (
        .clk(clk), .resetn(resetn), .f_req(f_req), .m_req(m_req),
        .i_valid(i_valid), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
        .d_valid(d_valid), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .e_memtoreg(e_memtoreg), .e_wreg(e_wreg), .d_rs(d_rs), .d_rt(d_rt),
        .instr(instr), .mdata(mdata),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW)
    );

    always #5 clk = ~clk;

    // Transaction view of one bus: a request in flight (address pending or
    // accepted), or a finished word parked until its stage advances.
    typedef struct packed {
        bit          busy;
        bit          addrDone;
        bit          held;
        logic [31:0] word;
    } busM_t;

    busM_t ib, db;

    function automatic void busEval(input busM_t s, input bit rq, input bit aok, input bit dok,
                                    output bit vld, output bit dn, output bit wt);
        bit issuing, accepted;
        if (s.held) begin
            vld = 0; dn = 1; wt = 0;
        end else begin
            issuing  = s.busy ? !s.addrDone : rq;
            accepted = (s.busy && s.addrDone) || (issuing && aok);
            vld = issuing;
            dn  = accepted && dok;
            wt  = !dn && (s.busy || rq);
        end
    endfunction

    function automatic busM_t busNext(input busM_t s, input bit rq, input bit aok, input bit dok,
                                      input bit go, input logic [31:0] rd);
        busM_t n;
        bit vld, dn, wt, issuing;
        n = s;
        if (s.held) begin
            if (go) n.held = 0;
        end else begin
            busEval(s, rq, aok, dok, vld, dn, wt);
            issuing = vld;
            if (dn) begin
                n.busy = 0; n.addrDone = 0;
                if (!go) begin n.held = 1; n.word = rd; end
            end else if (issuing) begin
                n.busy = 1; n.addrDone = aok;
            end
        end
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [8:0] dutVec();
        return {StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, FlushM, FlushW};
    endfunction

    // Compare at the falling edge, then advance the model to the next rising edge.
    task automatic step();
        bit iv, idn, iw, dv, ddn, dw, lu;
        logic [8:0] ev;
        @(negedge clk);
        busEval(ib, f_req, i_addr_ok, i_data_ok, iv, idn, iw);
        busEval(db, m_req, d_addr_ok, d_data_ok, dv, ddn, dw);
        lu = e_memtoreg && e_wreg != 0 && (e_wreg == d_rs || e_wreg == d_rt);
        ev = dw ? PAT_D : lu ? PAT_LU : iw ? PAT_I : 9'b0;
        if (!resetn) begin
            chk("rst_i_valid", {31'b0, i_valid}, 0);
            chk("rst_d_valid", {31'b0, d_valid}, 0);
            chk("rst_ctl", {23'b0, dutVec()}, 0);
            ib = '0; db = '0;
        end else begin
            chk("i_valid", {31'b0, i_valid}, {31'b0, iv});
            chk("d_valid", {31'b0, d_valid}, {31'b0, dv});
            chk("ctl", {23'b0, dutVec()}, {23'b0, ev});
            chk("instr", instr, ib.held ? ib.word : i_rdata);
            chk("mdata", mdata, db.held ? db.word : d_rdata);
            ib = busNext(ib, f_req, i_addr_ok, i_data_ok, !ev[8], i_rdata);
            db = busNext(db, m_req, d_addr_ok, d_data_ok, !ev[5], d_rdata);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        f_req = 0; m_req = 0; i_addr_ok = 0; i_data_ok = 0; d_addr_ok = 0; d_data_ok = 0;
        e_memtoreg = 0; e_wreg = 0; d_rs = 0; d_rt = 0;
    endtask

    initial begin
        ib = '0; db = '0;
        resetn = 0; quiet(); i_rdata = 32'h0; d_rdata = 32'h0;
        f_req = 1; m_req = 1;
        step(); nxt(); step(); nxt();
        chk("reset_ctl_lit", {23'b0, dutVec()}, 0);

        // Same-cycle handshake completes with no stall.
        resetn = 1; quiet(); f_req = 1; i_addr_ok = 1; i_data_ok = 1; i_rdata = 32'h24080001;
        step();
        chk("zero_lat_instr", instr, 32'h24080001);
        chk("zero_lat_ctl", {23'b0, dutVec()}, 0);
        nxt(); quiet(); step();
        chk("zero_lat_idle", {31'b0, i_valid}, 0);

        // addr_ok at cycle 0, data_ok at cycle 3.
        nxt(); quiet(); f_req = 1; i_addr_ok = 1; step();
        chk("slow_c0_valid", {31'b0, i_valid}, 1);
        chk("slow_c0_ctl", {23'b0, dutVec()}, {23'b0, PAT_I});
        for (int c = 1; c < 3; c++) begin
            nxt(); i_addr_ok = 0; step();
            chk("slow_mid_valid", {31'b0, i_valid}, 0);
            chk("slow_mid_ctl", {23'b0, dutVec()}, {23'b0, PAT_I});
        end
        nxt(); i_data_ok = 1; i_rdata = 32'h11112222; step();
        chk("slow_c3_ctl", {23'b0, dutVec()}, 0);

        // ibus completes while dbus waits: parked in HOLD, delivered on release.
        nxt(); quiet(); m_req = 1; d_addr_ok = 1; f_req = 1; i_addr_ok = 1; step();
        chk("dw_c0_ctl", {23'b0, dutVec()}, {23'b0, PAT_D});
        nxt(); d_addr_ok = 0; i_addr_ok = 0; i_data_ok = 1; i_rdata = 32'h1234; step();
        chk("dw_c1_ctl", {23'b0, dutVec()}, {23'b0, PAT_D});
        chk("dw_c1_dvalid", {31'b0, d_valid}, 0);
        nxt(); i_data_ok = 0; i_rdata = 32'hdeadbeef; d_data_ok = 1; d_rdata = 32'h5a5a; step();
        chk("dw_c2_ctl", {23'b0, dutVec()}, 0);
        chk("dw_c2_instr", instr, 32'h1234);
        chk("dw_c2_ivalid", {31'b0, i_valid}, 0);
        chk("dw_c2_mdata", mdata, 32'h5a5a);

        // Load-use, then no hazard on register 0.
        nxt(); quiet(); e_memtoreg = 1; e_wreg = 8; d_rt = 8; step();
        chk("lu_ctl", {23'b0, dutVec()}, {23'b0, PAT_LU});
        nxt(); e_wreg = 0; d_rt = 0; d_rs = 0; step();
        chk("lu_r0_ctl", {23'b0, dutVec()}, 0);

        // Load-use together with a dbus wait; valid held after req drops.
        nxt(); e_wreg = 8; d_rs = 8; m_req = 1; step();
        chk("lu_dw_ctl", {23'b0, dutVec()}, {23'b0, PAT_D});
        nxt(); quiet(); d_addr_ok = 1; d_data_ok = 1; step();
        chk("addr_hold_valid", {31'b0, d_valid}, 1);

        // Reset abandons an ibus transaction; late data_ok ignored.
        nxt(); quiet(); f_req = 1; i_addr_ok = 1; step();
        nxt(); quiet(); resetn = 0; step();
        nxt(); resetn = 1; i_data_ok = 1; i_rdata = 32'h55; step();
        chk("late_ctl", {23'b0, dutVec()}, 0);
        chk("late_instr", instr, 32'h55);
        nxt(); i_data_ok = 0; step();
        chk("late_ivalid", {31'b0, i_valid}, 0);

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            nxt();
            resetn     = ($urandom_range(63) != 0);
            f_req      = $urandom_range(3) != 0;
            m_req      = $urandom_range(2) == 0;
            i_addr_ok  = $urandom_range(1);
            i_data_ok  = $urandom_range(2) == 0;
            d_addr_ok  = $urandom_range(1);
            d_data_ok  = $urandom_range(2) == 0;
            i_rdata    = $urandom;
            d_rdata    = $urandom;
            e_memtoreg = $urandom_range(1);
            e_wreg     = 5'($urandom_range(3));
            d_rs       = 5'($urandom_range(3));
            d_rt       = 5'($urandom_range(3));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
